pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the ID stage. It takes hazard inputs: load-use from ID/EX, branch/jump from ID, and a busy signal from the data-memory port. It drives the PC, IF/ID, ID/EX and EX/MEM write enables, the IF/ID flush and the ID/EX bubble. It also keeps stall, flush and cycle counters that the bench reads hierarchically.

Parameters:
STALL_CYCLES, 1, load-use bubbles inserted per hazard (2 when a branch that consumes the load result resolves in ID); legal range 1..3
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  pipeline clock
start_i  in  1  asynchronous active-low reset; low = pipeline held in reset
ex_memread_i  in  1  instruction in EX is a load
ex_rt_i  in  5  load destination register in EX
id_rs_i  in  5  rs of the instruction in ID
id_rt_i  in  5  rt of the instruction in ID
id_uses_rt_i  in  1  instruction in ID reads rt (R-type, beq, sw)
branch_taken_i  in  1  branch in ID resolved taken
jump_i  in  1  jump decoded in ID
dmem_busy_i  in  1  data memory has not completed its access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  zero the IF/ID instruction
idex_bubble_o  out  1  force ID/EX control bits to zero
idex_write_o  out  1  ID/EX write enable
exmem_write_o  out  1  EX/MEM and MEM/WB write enable
stall_cnt_o  out  CNT_W  load-use bubble cycles
flush_cnt_o  out  CNT_W  flush cycles
cycle_cnt_o  out  CNT_W  cycles since start_i rose

Behaviour:
- Reset (start_i=0, async):
  - state=RUN, remaining-bubble count=0, all counters=0.
  - All write enables=1; ifid_flush_o=0; idex_bubble_o=0.
- Load-use hazard, lu = ex_memread_i & (ex_rt_i!=0) & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Outputs are combinational from state plus inputs. Registers update on posedge clk_i.
- States: RUN, LU_STALL, MEM_WAIT. A resume register holds RUN or LU_STALL plus the remaining count.
- Priority, highest first: dmem_busy_i freeze, then load-use bubble, then flush.
- Freeze (dmem_busy_i=1, any state):
  - All four write enables=0; ifid_flush_o=0; idex_bubble_o=0.
  - On entry, state goes to MEM_WAIT and the current state and count are saved.
  - Stall and flush counters hold.
- MEM_WAIT: exits in the first cycle dmem_busy_i=0, back to the saved state. The saved count is not decremented during the freeze.
- RUN with lu=1:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; ifid_flush_o suppressed even if branch_taken_i/jump_i=1 (the branch re-evaluates after the stall).
  - If STALL_CYCLES>1, go to LU_STALL with count=STALL_CYCLES-1.
- LU_STALL: same outputs as the load-use bubble, regardless of lu. Count decrements each cycle; leave to RUN when count reaches 1.
- RUN with lu=0 and (branch_taken_i | jump_i): ifid_flush_o=1 for that cycle only; PC writes (target is loaded by the PC mux).
- Counters (cycle_cnt_o, stall_cnt_o, flush_cnt_o):
  - Increment on every clk_i edge after reset, while the respective condition holds.
  - cycle_cnt_o counts every cycle; stall_cnt_o counts cycles with idex_bubble_o=1; flush_cnt_o counts cycles with ifid_flush_o=1.
  - All counters saturate at all-ones; no wrap.
- Reset asserted mid-stall or mid-freeze: immediate return to RUN, outputs go to their reset values.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: three counters as above.
- Undefined: counter registers removed; stall_cnt_o, flush_cnt_o and cycle_cnt_o tied to 0.
- Stall/flush control is identical in both builds.

Test Plan:
- Reset: hold start_i=0 two cycles, then release → all enables=1, flush=0, bubble=0, counters=0; after 10 free cycles cycle_cnt_o=10.
- Load-use on rs: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for one cycle, STALL_CYCLES=1 → one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, then resume; stall_cnt_o=1.
- Load-use + branch: STALL_CYCLES=2, lu=1 with branch_taken_i=1 → two bubble cycles with ifid_flush_o=0; branch_taken_i=1 in the next cycle → ifid_flush_o=1 for one cycle; stall_cnt_o=2, flush_cnt_o=1.
- No false hazard: ex_rt_i=0=id_rs_i, ex_memread_i=1 → no bubble. ex_rt_i=9=id_rt_i with id_uses_rt_i=0 → no bubble.
- Memory freeze mid-stall: STALL_CYCLES=3, dmem_busy_i=1 for 4 cycles during the second bubble → all enables 0 for 4 cycles, then the remaining bubbles complete; stall_cnt_o=3.
- Async reset mid-LU_STALL: drop start_i between clock edges → outputs go to reset values immediately, no clock required.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and pipeline-control outputs exchanged between
// the pipeline datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if;
    logic       ex_memread_i;
    logic [4:0] ex_rt_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rt_i;
    logic       branch_taken_i;
    logic       jump_i;
    logic       dmem_busy_i;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       idex_bubble_o;
    logic       idex_write_o;
    logic       exmem_write_o;

    modport master (
        output ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i,
               branch_taken_i, jump_i, dmem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               idex_write_o, exmem_write_o
    );

    modport slave (
        input  ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i,
               branch_taken_i, jump_i, dmem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               idex_write_o, exmem_write_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Stall/flush/cycle performance counters exist only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk_i,
    input  logic                  start_i,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      cycle_cnt_o
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    state_t     resume_state_r;
    state_t     next_resume_state_s;
    state_t     eff_state_s;
    logic [1:0] cnt_r;
    logic [1:0] next_cnt_s;
    logic [1:0] resume_cnt_r;
    logic [1:0] next_resume_cnt_s;
    logic [1:0] eff_cnt_s;
    logic       lu_s;
    logic       pc_write_s;
    logic       ifid_write_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;
    logic       idex_write_s;
    logic       exmem_write_s;

    assign lu_s = hz.ex_memread_i & (hz.ex_rt_i != 5'd0) &
                  ((hz.ex_rt_i == hz.id_rs_i) |
                   (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i)));

    // Once memory stops being busy, the frozen state acts again in that same cycle.
    assign eff_state_s = (state_r == MEM_WAIT) ? resume_state_r : state_r;
    assign eff_cnt_s   = (state_r == MEM_WAIT) ? resume_cnt_r   : cnt_r;

    // Next-state and control outputs; freeze beats load-use, load-use beats flush.
    always_comb begin
        pc_write_s          = 1'b1;
        ifid_write_s        = 1'b1;
        ifid_flush_s        = 1'b0;
        idex_bubble_s       = 1'b0;
        idex_write_s        = 1'b1;
        exmem_write_s       = 1'b1;
        next_state_s        = eff_state_s;
        next_cnt_s          = eff_cnt_s;
        next_resume_state_s = resume_state_r;
        next_resume_cnt_s   = resume_cnt_r;
        if (!start_i) begin
            next_state_s = RUN;
            next_cnt_s   = 2'd0;
        end else if (hz.dmem_busy_i) begin
            pc_write_s          = 1'b0;
            ifid_write_s        = 1'b0;
            idex_write_s        = 1'b0;
            exmem_write_s       = 1'b0;
            next_state_s        = MEM_WAIT;
            next_cnt_s          = cnt_r;
            next_resume_state_s = eff_state_s;
            next_resume_cnt_s   = eff_cnt_s;
        end else begin
            case (eff_state_s)
                RUN: begin
                    if (lu_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            next_state_s = LU_STALL;
                            next_cnt_s   = 2'(STALL_CYCLES - 1);
                        end else begin
                            next_state_s = RUN;
                            next_cnt_s   = 2'd0;
                        end
                    end else if (hz.branch_taken_i | hz.jump_i) begin
                        ifid_flush_s = 1'b1;
                    end else begin
                        ifid_flush_s = 1'b0;
                    end
                end
                LU_STALL: begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_bubble_s = 1'b1;
                    if (eff_cnt_s <= 2'd1) begin
                        next_state_s = RUN;
                        next_cnt_s   = 2'd0;
                    end else begin
                        next_cnt_s = eff_cnt_s - 2'd1;
                    end
                end
                default: begin
                    next_state_s = RUN;
                    next_cnt_s   = 2'd0;
                end
            endcase
        end
    end

    // Sequencer state, bubble count and the context saved across a memory freeze.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_r        <= RUN;
            cnt_r          <= 2'd0;
            resume_state_r <= RUN;
            resume_cnt_r   <= 2'd0;
        end else begin
            state_r        <= next_state_s;
            cnt_r          <= next_cnt_s;
            resume_state_r <= next_resume_state_s;
            resume_cnt_r   <= next_resume_cnt_s;
        end
    end

    assign hz.pc_write_o    = pc_write_s;
    assign hz.ifid_write_o  = ifid_write_s;
    assign hz.ifid_flush_o  = ifid_flush_s;
    assign hz.idex_bubble_o = idex_bubble_s;
    assign hz.idex_write_o  = idex_write_s;
    assign hz.exmem_write_o = exmem_write_s;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] cycle_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating performance counters sampled from the current-cycle controls.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
            cycle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_r <= sat_inc(cycle_cnt_r);
            if (idex_bubble_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
    assign cycle_cnt_o = cycle_cnt_r;
`else
    assign stall_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o = {CNT_W{1'b0}};
    assign cycle_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench driving three sequencers (STALL_CYCLES 1..3)
// with the same directed vectors; each vector's expectation targets one instance.
module tb_pipeline_hazard_ctrl;
    // Expected control word order: {pc, ifid_write, ifid_flush, idex_bubble, idex_write, exmem}
    localparam logic [5:0] NORM = 6'b110011;
    localparam logic [5:0] BUB  = 6'b000111;
    localparam logic [5:0] FLS  = 6'b111011;
    localparam logic [5:0] FRZ  = 6'b000000;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string      nm;
        int         sel;
        logic [5:0] ctl;
        bit         chk;
        int         es;
        int         ef;
        int         ec;
    } exp_t;

    bit         clk = 1'b0;
    logic       start;
    logic       memrd;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       jp;
    logic       bz;
    logic [5:0]  act_ctl   [1:3];
    logic [31:0] act_stall [1:3];
    logic [31:0] act_flush [1:3];
    logic [31:0] act_cycle [1:3];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_hazard_ctrl_if hz ();
        logic [31:0] st_c;
        logic [31:0] fl_c;
        logic [31:0] cy_c;

        assign hz.ex_memread_i   = memrd;
        assign hz.ex_rt_i        = ert;
        assign hz.id_rs_i        = rs;
        assign hz.id_rt_i        = rt;
        assign hz.id_uses_rt_i   = ur;
        assign hz.branch_taken_i = br;
        assign hz.jump_i         = jp;
        assign hz.dmem_busy_i    = bz;

        pipeline_hazard_ctrl #(.STALL_CYCLES(g + 1), .CNT_W(32)) u_dut (
            .clk_i       (clk),
            .start_i     (start),
            .hz          (hz),
            .stall_cnt_o (st_c),
            .flush_cnt_o (fl_c),
            .cycle_cnt_o (cy_c)
        );

        assign act_ctl[g+1]   = {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o,
                                 hz.idex_bubble_o, hz.idex_write_o, hz.exmem_write_o};
        assign act_stall[g+1] = st_c;
        assign act_flush[g+1] = fl_c;
        assign act_cycle[g+1] = cy_c;
    end

    task automatic push(input string nm, input int sel, input logic [5:0] ctl,
                        input bit chk, input int es, input int ef, input int ec);
        exp_t e;
        e.nm = nm; e.sel = sel; e.ctl = ctl; e.chk = chk; e.es = es; e.ef = ef; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input int sel, input logic m, input logic [4:0] x_rt,
                        input logic [4:0] x_rs, input logic [4:0] x_idrt, input logic u,
                        input logic b, input logic j, input logic busy, input logic [5:0] ctl,
                        input bit chk, input int es, input int ef, input int ec);
        memrd = m; ert = x_rt; rs = x_rs; rt = x_idrt; ur = u; br = b; jp = j; bz = busy;
        push(nm, sel, ctl, chk, es, ef, ec);
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm, input int sel, input logic [5:0] ctl,
                        input bit chk, input int es, input int ef, input int ec);
        step(nm, sel, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, chk, es, ef, ec);
    endtask

    task automatic rst_seq(input int sel);
        start = 1'b0;
        memrd = 1'b0; ert = 5'd0; rs = 5'd0; rt = 5'd0; ur = 1'b0; br = 1'b0; jp = 1'b0; bz = 1'b0;
        push("reset_hold", sel, NORM, 1'b1, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1;
    endtask

    // Monitor: one expectation is consumed at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (act_ctl[e.sel] !== e.ctl) begin
                    n_fail++;
                    $display("FAIL %s ctl (S=%0d): got %b expected %b", e.nm, e.sel, act_ctl[e.sel], e.ctl);
                end
                if (e.chk) begin
                    n_tests += 3;
                    if (act_stall[e.sel] !== 32'(PERF ? e.es : 0)) begin
                        n_fail++;
                        $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, act_stall[e.sel], PERF ? e.es : 0);
                    end
                    if (act_flush[e.sel] !== 32'(PERF ? e.ef : 0)) begin
                        n_fail++;
                        $display("FAIL %s flush_cnt: got %0d expected %0d", e.nm, act_flush[e.sel], PERF ? e.ef : 0);
                    end
                    if (act_cycle[e.sel] !== 32'(PERF ? e.ec : 0)) begin
                        n_fail++;
                        $display("FAIL %s cycle_cnt: got %0d expected %0d", e.nm, act_cycle[e.sel], PERF ? e.ec : 0);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and free-running cycle count
        rst_seq(1);
        idle("rst_state", 1, NORM, 1'b1, 0, 0, 0);
        for (int i = 0; i < 9; i++) idle("free_run", 1, NORM, 1'b0, 0, 0, 0);
        idle("cycle10", 1, NORM, 1'b1, 0, 0, 10);

        // Single-bubble load-use on rs and rt, then a jump flush
        rst_seq(1);
        step("lu_rs", 1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b1, 0, 0, 0);
        idle("lu_rs_resume", 1, NORM, 1'b1, 1, 0, 1);
        step("lu_rt", 1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 0, 0, 0);
        step("jump", 1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FLS, 1'b1, 2, 0, 3);
        idle("jump_after", 1, NORM, 1'b1, 2, 1, 4);
        // No false hazards
        step("x0_no_lu", 1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 0, 0, 0);
        step("rt_unused", 1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 0, 0, 0);
        step("no_load", 1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b1, 2, 1, 7);

        // Two-bubble load-use with a pending branch
        rst_seq(2);
        step("lu_br_0", 2, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BUB, 1'b1, 0, 0, 0);
        step("lu_br_1", 2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BUB, 1'b0, 0, 0, 0);
        step("br_flush", 2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FLS, 1'b1, 2, 0, 2);
        idle("br_after", 2, NORM, 1'b1, 2, 1, 3);
        for (int i = 0; i < 4; i++)
            step("lu_repeat", 2, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 0, 0, 0);
        idle("lu_repeat_end", 2, NORM, 1'b1, 6, 1, 8);

        // Memory freeze during the second of three bubbles, then a freeze from RUN
        rst_seq(3);
        step("frz_lu", 3, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b1, 0, 0, 0);
        step("frz_1", 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 0, 0, 0);
        step("frz_2_br", 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, FRZ, 1'b0, 0, 0, 0);
        step("frz_3_lu", 3, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b0, 0, 0, 0);
        step("frz_4", 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 1'b1, 1, 0, 4);
        idle("frz_bub2", 3, BUB, 1'b0, 0, 0, 0);
        idle("frz_bub3", 3, BUB, 1'b0, 0, 0, 0);
        idle("frz_done", 3, NORM, 1'b1, 3, 0, 7);
        step("frz_run_jp", 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FRZ, 1'b0, 0, 0, 0);
        step("jp_after_frz", 3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FLS, 1'b1, 3, 0, 9);
        idle("frz_final", 3, NORM, 1'b1, 3, 1, 10);

        // Asynchronous reset pulse between clock edges while in LU_STALL
        rst_seq(3);
        step("async_lu", 3, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BUB, 1'b0, 0, 0, 0);
        idle("async_stall", 3, BUB, 1'b0, 0, 0, 0);
        start = 1'b0;
        push("async_rst", 3, NORM, 1'b1, 0, 0, 0);
        #2;
        start = 1'b1;
        @(posedge clk); #1;
        idle("post_async", 3, NORM, 1'b1, 0, 0, 1);
        // Outputs held at reset values while reset is low even with hazards present
        start = 1'b0;
        memrd = 1'b1; ert = 5'd8; rs = 5'd8; br = 1'b1; bz = 1'b0;
        push("rst_gate", 3, NORM, 1'b1, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b1;
        idle("post_gate", 3, NORM, 1'b1, 0, 0, 0);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
